// File: rtl/pcie_pkg.sv
// rtl/pcie_pkg.sv - shared TLP constants, latched request record and FSM encoding for the completion path
package pcie_pkg;

    // TLP header format/type for 3DW completions
    localparam logic [1:0] C_FMT_3DW    = 2'b00;
    localparam logic [1:0] C_FMT_3DW_D  = 2'b10;
    localparam logic [4:0] C_TYPE_CPL   = 5'b01010;

    // Completion status: successful completion
    localparam logic [2:0] C_CPL_SC     = 3'b000;

    // TRN remainder codes (active low per byte of the 64-bit beat)
    localparam logic [7:0] C_TREM_BOTH  = 8'h00;
    localparam logic [7:0] C_TREM_UPPER = 8'h0F;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_BEAT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_DONE  = 3'd4
    } cpl_state_e;

    // Request fields captured when the completion is accepted
    typedef struct packed {
        logic        with_data;
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [3:0]  be;
        logic [4:0]  addr_hi;
        logic [15:0] cid;
    } cpl_req_t;

    // First header DW of a 3DW completion; Cpl carries no payload so its length is zero
    function automatic logic [31:0] cpl_dw0(
        input logic       with_data,
        input logic [2:0] tc,
        input logic       td,
        input logic       ep,
        input logic [1:0] attr,
        input logic [9:0] len
    );
        return {1'b0, (with_data ? C_FMT_3DW_D : C_FMT_3DW), C_TYPE_CPL, 1'b0, tc, 4'b0000,
                td, ep, attr, 2'b00, (with_data ? len : 10'd0)};
    endfunction

endpackage

// File: rtl/pcie_tx_cpl_if.sv
// rtl/pcie_tx_cpl_if.sv - 64-bit TRN transmit interface between completion engine and core
interface pcie_tx_cpl_if;

    logic [63:0] trn_td_o;
    logic [7:0]  trn_trem_n_o;
    logic        trn_tsof_n_o;
    logic        trn_teof_n_o;
    logic        trn_tsrc_rdy_n_o;
    logic        trn_tsrc_dsc_n_o;
    logic        trn_tdst_rdy_n_i;
    logic        trn_tdst_dsc_n_i;

    modport master (
        output trn_td_o, trn_trem_n_o, trn_tsof_n_o, trn_teof_n_o,
               trn_tsrc_rdy_n_o, trn_tsrc_dsc_n_o,
        input  trn_tdst_rdy_n_i, trn_tdst_dsc_n_i
    );

    modport slave (
        input  trn_td_o, trn_trem_n_o, trn_tsof_n_o, trn_teof_n_o,
               trn_tsrc_rdy_n_o, trn_tsrc_dsc_n_o,
        output trn_tdst_rdy_n_i, trn_tdst_dsc_n_i
    );

endinterface

// File: rtl/pcie_cpl_be_dec.sv
// rtl/pcie_cpl_be_dec.sv - first-DW byte-enable decode into completion byte count and lower address
module pcie_cpl_be_dec (
    input  logic [3:0]  be_i,
    input  logic [6:2]  addr_i,
    output logic [11:0] byte_count_o,
    output logic [6:0]  lower_addr_o
);

    logic [1:0] lo_bits;

    // Byte count spans first to last enabled byte; an empty mask still reports one byte
    always_comb begin
        byte_count_o = 12'd1;
        casez (be_i)
            4'b1??1:                   byte_count_o = 12'd4;
            4'b01?1, 4'b1?10:          byte_count_o = 12'd3;
            4'b0011, 4'b0110, 4'b1100: byte_count_o = 12'd2;
            default:                   byte_count_o = 12'd1;
        endcase
    end

    // Low address bits point at the first enabled byte
    always_comb begin
        lo_bits = 2'b00;
        casez (be_i)
            4'b???1: lo_bits = 2'b00;
            4'b??10: lo_bits = 2'b01;
            4'b?100: lo_bits = 2'b10;
            4'b1000: lo_bits = 2'b11;
            default: lo_bits = 2'b00;
        endcase
    end

    assign lower_addr_o = {addr_i, lo_bits};

endmodule

// File: rtl/pcie_tx_cpl.sv
// rtl/pcie_tx_cpl.sv - single-DW PIO completion transmitter onto the 64-bit TRN TX interface
module pcie_tx_cpl
    import pcie_pkg::*;
#(
    parameter int         G_RD_LATENCY = 1,
    parameter logic [2:0] G_CPL_STATUS = C_CPL_SC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_compl_i,
    input  logic          req_with_data_i,
    input  logic [2:0]    req_tc_i,
    input  logic          req_td_i,
    input  logic          req_ep_i,
    input  logic [1:0]    req_attr_i,
    input  logic [9:0]    req_len_i,
    input  logic [15:0]   req_rid_i,
    input  logic [7:0]    req_tag_i,
    input  logic [3:0]    req_be_i,
    input  logic [6:0]    req_addr_i,
    input  logic [15:0]   completer_id_i,
    input  logic [31:0]   rd_data_i,
    output logic          compl_done_o,
    output logic          compl_abort_o,
    pcie_tx_cpl_if.master trn
);

    localparam logic [2:0] C_LAT = 3'(G_RD_LATENCY);

    cpl_state_e  state_q, state_d;
    cpl_req_t    req_q, req_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic        abort_q, abort_d;

    logic [11:0] byte_count;
    logic [6:0]  lower_addr;
    logic [31:0] dw0, dw1, dw2;

    // Address bits [1:0] are regenerated from the byte enables, so the request copy is not kept
    logic [1:0]  addr_lo_unused;
    assign addr_lo_unused = req_addr_i[1:0];

    pcie_cpl_be_dec u_be_dec (
        .be_i         (req_q.be),
        .addr_i       (req_q.addr_hi),
        .byte_count_o (byte_count),
        .lower_addr_o (lower_addr)
    );

    assign dw0 = cpl_dw0(req_q.with_data, req_q.tc, req_q.td, req_q.ep, req_q.attr, req_q.len);
    assign dw1 = {req_q.cid, G_CPL_STATUS, 1'b0, byte_count};
    assign dw2 = {req_q.rid, req_q.tag, 1'b0, lower_addr};

    assign trn.trn_tsrc_dsc_n_o = 1'b1;

    // State, latched request, read data and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            rd_data_q  <= '0;
            wait_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rd_data_q  <= rd_data_d;
            wait_cnt_q <= wait_cnt_d;
            abort_q    <= abort_d;
        end
    end

    // Next-state logic and TRN beat generation; outputs follow the state register directly
    always_comb begin
        state_d                = state_q;
        req_d                  = req_q;
        rd_data_d              = rd_data_q;
        wait_cnt_d             = wait_cnt_q;
        abort_d                = abort_q;
        compl_done_o           = 1'b0;
        compl_abort_o          = 1'b0;
        trn.trn_td_o           = 64'd0;
        trn.trn_trem_n_o       = C_TREM_BOTH;
        trn.trn_tsof_n_o       = 1'b1;
        trn.trn_teof_n_o       = 1'b1;
        trn.trn_tsrc_rdy_n_o   = 1'b1;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (req_compl_i) begin
                    req_d.with_data = req_with_data_i;
                    req_d.tc        = req_tc_i;
                    req_d.td        = req_td_i;
                    req_d.ep        = req_ep_i;
                    req_d.attr      = req_attr_i;
                    req_d.len       = req_len_i;
                    req_d.rid       = req_rid_i;
                    req_d.tag       = req_tag_i;
                    req_d.be        = req_be_i;
                    req_d.addr_hi   = req_addr_i[6:2];
                    req_d.cid       = completer_id_i;
                    wait_cnt_d      = 3'd1;
                    state_d         = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == C_LAT) begin
                    rd_data_d = rd_data_i;
                    state_d   = S_BEAT0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            S_BEAT0: begin
                trn.trn_td_o         = {dw0, dw1};
                trn.trn_tsof_n_o     = 1'b0;
                trn.trn_tsrc_rdy_n_o = 1'b0;
                if (!trn.trn_tdst_dsc_n_i) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else if (!trn.trn_tdst_rdy_n_i) begin
                    state_d = S_BEAT1;
                end
            end
            S_BEAT1: begin
                trn.trn_td_o         = {dw2, (req_q.with_data ? rd_data_q : 32'd0)};
                trn.trn_trem_n_o     = req_q.with_data ? C_TREM_BOTH : C_TREM_UPPER;
                trn.trn_teof_n_o     = 1'b0;
                trn.trn_tsrc_rdy_n_o = 1'b0;
                if (!trn.trn_tdst_dsc_n_i) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else if (!trn.trn_tdst_rdy_n_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                compl_done_o  = 1'b1;
                compl_abort_o = abort_q;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pcie_tx_cpl.sv
// tb/tb_pcie_tx_cpl.sv - randomized self-checking bench for the completion transmitter
module tb_pcie_tx_cpl;

    localparam int L = 2;

    typedef struct {
        logic        wd;
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [3:0]  be;
        logic [6:0]  addr;
        logic [15:0] cid;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_compl_i, req_with_data_i, req_td_i, req_ep_i;
    logic [2:0]  req_tc_i;
    logic [1:0]  req_attr_i;
    logic [9:0]  req_len_i;
    logic [15:0] req_rid_i, completer_id_i;
    logic [7:0]  req_tag_i;
    logic [3:0]  req_be_i;
    logic [6:0]  req_addr_i;
    logic [31:0] rd_data_i;
    logic        compl_done_o, compl_abort_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] cap_td [2];
    logic        cap_sof [2];
    logic        cap_eof [2];
    logic [7:0]  cap_trem [2];
    int          cap_nb, cap_first, cap_done_k, cap_done_cnt, cap_extra, cap_unstable, cap_dsc_k;
    logic        cap_abort, cap_stray, cap_timeout, cap_dsc_bad;

    pcie_tx_cpl_if trn_if ();

    pcie_tx_cpl #(.G_RD_LATENCY(L), .G_CPL_STATUS(3'b000)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_compl_i     (req_compl_i),
        .req_with_data_i (req_with_data_i),
        .req_tc_i        (req_tc_i),
        .req_td_i        (req_td_i),
        .req_ep_i        (req_ep_i),
        .req_attr_i      (req_attr_i),
        .req_len_i       (req_len_i),
        .req_rid_i       (req_rid_i),
        .req_tag_i       (req_tag_i),
        .req_be_i        (req_be_i),
        .req_addr_i      (req_addr_i),
        .completer_id_i  (completer_id_i),
        .rd_data_i       (rd_data_i),
        .compl_done_o    (compl_done_o),
        .compl_abort_o   (compl_abort_o),
        .trn             (trn_if.master)
    );

    always #5 clk = ~clk;

    // Reference model: byte count spans first..last enabled byte, empty mask counts as one byte
    function automatic logic [11:0] m_bc(input logic [3:0] be);
        int lo = -1;
        int hi = -1;
        for (int i = 0; i < 4; i++) if (be[i]) begin if (lo < 0) lo = i; hi = i; end
        if (lo < 0) return 12'd1;
        return 12'(hi - lo + 1);
    endfunction

    function automatic logic [1:0] m_lo(input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic logic [63:0] m_beat0(input req_t r);
        logic [31:0] w0, w1;
        w0 = {1'b0, (r.wd ? 2'b10 : 2'b00), 5'b01010, 1'b0, r.tc, 4'h0, r.td, r.ep, r.attr, 2'b00, (r.wd ? r.len : 10'd0)};
        w1 = {r.cid, 3'b000, 1'b0, m_bc(r.be)};
        return {w0, w1};
    endfunction

    function automatic logic [63:0] m_beat1(input req_t r);
        return {r.rid, r.tag, 1'b0, r.addr[6:2], m_lo(r.be), (r.wd ? r.data : 32'h0)};
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.wd   = 1'($urandom_range(0, 1));
        r.tc   = 3'($urandom);
        r.td   = 1'($urandom);
        r.ep   = 1'($urandom);
        r.attr = 2'($urandom);
        r.len  = 10'($urandom_range(0, 1));
        r.rid  = 16'($urandom);
        r.tag  = 8'($urandom);
        r.be   = 4'($urandom);
        r.addr = 7'($urandom);
        r.cid  = 16'($urandom);
        r.data = $urandom;
        return r;
    endfunction

    task automatic drive_fields(input req_t r);
        req_with_data_i = r.wd;   req_tc_i  = r.tc;  req_td_i   = r.td;   req_ep_i  = r.ep;
        req_attr_i      = r.attr; req_len_i = r.len; req_rid_i  = r.rid;  req_tag_i = r.tag;
        req_be_i        = r.be;   req_addr_i = r.addr; completer_id_i = r.cid;
    endtask

    // Issues one request and records what appears on TRN; stalls per beat, optional discontinue on beat dsc_beat
    task automatic capture(input req_t r, input int st0, input int st1, input int dsc_beat);
        int   stall [2];
        int   nb;
        logic pend;
        logic [63:0] p_td;
        logic [10:0] p_ctl;
        logic src;
        logic [10:0] ctl;
        stall[0] = st0; stall[1] = st1; nb = 0; pend = 1'b0; p_td = '0; p_ctl = '0;
        for (int i = 0; i < 2; i++) begin cap_td[i] = '0; cap_sof[i] = 1'b1; cap_eof[i] = 1'b1; cap_trem[i] = '0; end
        cap_first = -1; cap_done_k = -1; cap_done_cnt = 0; cap_extra = 0; cap_unstable = 0; cap_dsc_k = -1;
        cap_abort = 1'b0; cap_stray = 1'b0; cap_timeout = 1'b0; cap_dsc_bad = 1'b0;
        @(negedge clk);
        drive_fields(r);
        req_compl_i = 1'b1;
        rd_data_i = $urandom;
        trn_if.trn_tdst_rdy_n_i = 1'b0;
        trn_if.trn_tdst_dsc_n_i = 1'b1;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            src = trn_if.trn_tsrc_rdy_n_o;
            ctl = {trn_if.trn_tsof_n_o, trn_if.trn_teof_n_o, trn_if.trn_trem_n_o, src};
            if (trn_if.trn_tsrc_dsc_n_o !== 1'b1) cap_dsc_bad = 1'b1;
            if (compl_done_o === 1'b1) begin
                cap_done_cnt++;
                if (cap_done_k < 0) cap_done_k = k;
                cap_abort = compl_abort_o;
            end else if (compl_abort_o !== 1'b0) begin
                cap_stray = 1'b1;
            end
            trn_if.trn_tdst_dsc_n_i = 1'b1;
            if (src === 1'b0) begin
                if (cap_first < 0) cap_first = k;
                if (cap_done_k >= 0) cap_extra++;
                if (pend && (trn_if.trn_td_o !== p_td || ctl !== p_ctl)) cap_unstable++;
                if (nb == dsc_beat) begin
                    trn_if.trn_tdst_dsc_n_i = 1'b0;
                    trn_if.trn_tdst_rdy_n_i = 1'b1;
                    cap_dsc_k = k;
                    dsc_beat = -1;
                    pend = 1'b0;
                end else if (nb < 2 && stall[nb] > 0) begin
                    stall[nb]--;
                    trn_if.trn_tdst_rdy_n_i = 1'b1;
                    pend = 1'b1;
                end else begin
                    trn_if.trn_tdst_rdy_n_i = 1'b0;
                    if (nb < 2) begin
                        cap_td[nb] = trn_if.trn_td_o; cap_sof[nb] = trn_if.trn_tsof_n_o;
                        cap_eof[nb] = trn_if.trn_teof_n_o; cap_trem[nb] = trn_if.trn_trem_n_o;
                    end else begin
                        cap_extra++;
                    end
                    nb++;
                    pend = 1'b0;
                end
                p_td = trn_if.trn_td_o;
                p_ctl = ctl;
            end else begin
                if (pend) cap_unstable++;
                pend = 1'b0;
                trn_if.trn_tdst_rdy_n_i = 1'($urandom_range(0, 1));
            end
            rd_data_i = (k == L) ? r.data : $urandom;
            drive_fields(rand_req());
            if (compl_done_o === 1'b1) req_compl_i = 1'b0;
            if (cap_done_k >= 0 && k >= cap_done_k + 3) break;
        end
        req_compl_i = 1'b0;
        trn_if.trn_tdst_dsc_n_i = 1'b1;
        cap_nb = nb;
        if (cap_done_k < 0) cap_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({compl_done_o, compl_abort_o} !== 2'b00) begin
            errors++; $display("FAIL reset_done got %b required 00", {compl_done_o, compl_abort_o});
        end
        checks++;
        if ({trn_if.trn_tsof_n_o, trn_if.trn_teof_n_o, trn_if.trn_tsrc_rdy_n_o, trn_if.trn_tsrc_dsc_n_o} !== 4'hF) begin
            errors++; $display("FAIL reset_strobes got %b required 1111", {trn_if.trn_tsof_n_o, trn_if.trn_teof_n_o, trn_if.trn_tsrc_rdy_n_o, trn_if.trn_tsrc_dsc_n_o});
        end
        checks++;
        if ({trn_if.trn_td_o, trn_if.trn_trem_n_o} !== 72'd0) begin
            errors++; $display("FAIL reset_data got %h/%h required 0/00", trn_if.trn_td_o, trn_if.trn_trem_n_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_cpld_basic();
        req_t r;
        r = rand_req();
        r.wd = 1'b1; r.be = 4'hF; r.addr = 7'h24; r.len = 10'd1; r.tag = 8'h5A;
        r.tc = 3'd0; r.td = 1'b0; r.ep = 1'b0; r.attr = 2'd0;
        capture(r, 0, 0, -1);
        checks++;
        if (cap_td[0] !== {32'h4A000001, r.cid, 4'h0, 12'd4}) begin
            errors++; $display("FAIL cpld_beat0 got %h required %h", cap_td[0], {32'h4A000001, r.cid, 4'h0, 12'd4});
        end
        checks++;
        if (cap_td[1] !== {r.rid, 8'h5A, 8'h24, r.data}) begin
            errors++; $display("FAIL cpld_beat1 got %h required %h", cap_td[1], {r.rid, 8'h5A, 8'h24, r.data});
        end
        checks++;
        if ({cap_sof[0], cap_eof[0], cap_sof[1], cap_eof[1], cap_trem[0], cap_trem[1]} !== {4'b0110, 16'h0000}) begin
            errors++; $display("FAIL cpld_ctl got %b %b %b %b %h %h", cap_sof[0], cap_eof[0], cap_sof[1], cap_eof[1], cap_trem[0], cap_trem[1]);
        end
        checks++;
        if (cap_first != L + 1 || cap_done_k != L + 3) begin
            errors++; $display("FAIL cpld_timing got first=%0d done=%0d required %0d/%0d", cap_first, cap_done_k, L + 1, L + 3);
        end
        checks++;
        if (cap_nb != 2 || cap_done_cnt != 1 || cap_abort !== 1'b0 || cap_extra != 0 || cap_stray || cap_dsc_bad || cap_timeout) begin
            errors++; $display("FAIL cpld_proto got nb=%0d done=%0d abort=%b extra=%0d required 2/1/0/0", cap_nb, cap_done_cnt, cap_abort, cap_extra);
        end
    endtask

    task automatic test_cpl_nodata();
        req_t r;
        r = rand_req();
        r.wd = 1'b0; r.be = 4'h0; r.len = 10'd1;
        capture(r, 0, 0, -1);
        checks++;
        if (cap_td[0][63:56] !== 8'h0A || cap_td[0][41:32] !== 10'd0 || cap_td[0][11:0] !== 12'd1) begin
            errors++; $display("FAIL cpl_hdr got %h required fmt=00 len=0 bc=1", cap_td[0]);
        end
        checks++;
        if (cap_td[1] !== {r.rid, r.tag, 1'b0, r.addr & 7'h7C, 32'h0} || cap_td[0] !== m_beat0(r)) begin
            errors++; $display("FAIL cpl_beats got %h %h required %h %h", cap_td[0], cap_td[1], m_beat0(r), m_beat1(r));
        end
        checks++;
        if (cap_trem[1] !== 8'h0F || cap_done_cnt != 1 || cap_nb != 2) begin
            errors++; $display("FAIL cpl_trem got trem=%h done=%0d nb=%0d required 0f/1/2", cap_trem[1], cap_done_cnt, cap_nb);
        end
    endtask

    task automatic test_be_sweep();
        req_t r;
        for (int b = 0; b < 16; b++) begin
            r = rand_req();
            r.wd = 1'b1; r.be = 4'(b); r.addr = 7'h40;
            capture(r, 0, 0, -1);
            checks++;
            if (cap_td[0][11:0] !== m_bc(r.be) || cap_td[1][38:32] !== {5'h10, m_lo(r.be)}) begin
                errors++; $display("FAIL be_sweep be=%h got bc=%0d la=%h required bc=%0d la=%h", r.be, cap_td[0][11:0], cap_td[1][38:32], m_bc(r.be), {5'h10, m_lo(r.be)});
            end
            if (b == 8) begin
                checks++;
                if (cap_td[0][11:0] !== 12'd1 || cap_td[1][38:32] !== 7'h43) begin
                    errors++; $display("FAIL be_1000 got bc=%0d la=%h required 1/43", cap_td[0][11:0], cap_td[1][38:32]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        req_t r;
        r = rand_req();
        capture(r, 5, 3, -1);
        checks++;
        if ({cap_td[0], cap_td[1]} !== {m_beat0(r), m_beat1(r)}) begin
            errors++; $display("FAIL bp_beats got %h %h required %h %h", cap_td[0], cap_td[1], m_beat0(r), m_beat1(r));
        end
        checks++;
        if (cap_unstable != 0 || cap_done_cnt != 1 || cap_nb != 2 || cap_extra != 0) begin
            errors++; $display("FAIL bp_proto got unstable=%0d done=%0d nb=%0d extra=%0d required 0/1/2/0", cap_unstable, cap_done_cnt, cap_nb, cap_extra);
        end
        checks++;
        if (cap_done_k != L + 3 + 8 || cap_first != L + 1) begin
            errors++; $display("FAIL bp_timing got first=%0d done=%0d required %0d/%0d", cap_first, cap_done_k, L + 1, L + 11);
        end
    endtask

    task automatic test_discontinue();
        req_t r;
        r = rand_req();
        capture(r, 0, 1, 1);
        checks++;
        if (cap_nb != 1 || cap_td[0] !== m_beat0(r) || cap_extra != 0) begin
            errors++; $display("FAIL dsc_beats got nb=%0d beat0=%h extra=%0d required 1/%h/0", cap_nb, cap_td[0], cap_extra, m_beat0(r));
        end
        checks++;
        if (cap_done_cnt != 1 || cap_abort !== 1'b1 || cap_dsc_k < 0 || cap_done_k != cap_dsc_k + 1 || cap_stray) begin
            errors++; $display("FAIL dsc_abort got done=%0d abort=%b dsc_k=%0d done_k=%0d required 1/1/done_k=dsc_k+1", cap_done_cnt, cap_abort, cap_dsc_k, cap_done_k);
        end
        r = rand_req();
        capture(r, 0, 0, -1);
        checks++;
        if ({cap_td[0], cap_td[1]} !== {m_beat0(r), m_beat1(r)} || cap_abort !== 1'b0 || cap_done_cnt != 1) begin
            errors++; $display("FAIL dsc_recover got %h %h abort=%b required %h %h 0", cap_td[0], cap_td[1], cap_abort, m_beat0(r), m_beat1(r));
        end
    endtask

    task automatic test_reset_mid();
        req_t r;
        int   seen;
        r = rand_req();
        seen = 0;
        @(negedge clk);
        drive_fields(r);
        req_compl_i = 1'b1;
        rd_data_i = r.data;
        trn_if.trn_tdst_rdy_n_i = 1'b1;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (trn_if.trn_tsrc_rdy_n_o === 1'b0) seen = 1;
        end
        checks++;
        if (seen == 0) begin
            errors++; $display("FAIL rst_mid_beat0 got no beat within 20 cycles required beat0");
        end
        rst = 1'b1;
        req_compl_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({trn_if.trn_tsof_n_o, trn_if.trn_teof_n_o, trn_if.trn_tsrc_rdy_n_o, compl_done_o, compl_abort_o} !== 5'b11100 || trn_if.trn_td_o !== 64'd0) begin
            errors++; $display("FAIL rst_mid_outputs got %b td=%h required 11100 td=0", {trn_if.trn_tsof_n_o, trn_if.trn_teof_n_o, trn_if.trn_tsrc_rdy_n_o, compl_done_o, compl_abort_o}, trn_if.trn_td_o);
        end
        rst = 1'b0;
        r = rand_req();
        capture(r, 1, 0, -1);
        checks++;
        if ({cap_td[0], cap_td[1]} !== {m_beat0(r), m_beat1(r)} || cap_done_cnt != 1 || cap_nb != 2 || cap_extra != 0) begin
            errors++; $display("FAIL rst_mid_newtlp got %h %h done=%0d nb=%0d required %h %h 1 2", cap_td[0], cap_td[1], cap_done_cnt, cap_nb, m_beat0(r), m_beat1(r));
        end
    endtask

    task automatic test_random();
        req_t r;
        int   s0, s1;
        for (int n = 0; n < 20; n++) begin
            r = rand_req();
            s0 = $urandom_range(0, 3);
            s1 = $urandom_range(0, 3);
            capture(r, s0, s1, -1);
            checks++;
            if ({cap_td[0], cap_td[1]} !== {m_beat0(r), m_beat1(r)} || cap_trem[1] !== (r.wd ? 8'h00 : 8'h0F)) begin
                errors++; $display("FAIL rand%0d_beats got %h %h trem=%h required %h %h", n, cap_td[0], cap_td[1], cap_trem[1], m_beat0(r), m_beat1(r));
            end
            checks++;
            if (cap_done_k != L + 3 + s0 + s1 || cap_done_cnt != 1 || cap_unstable != 0 || cap_extra != 0 || cap_timeout) begin
                errors++; $display("FAIL rand%0d_proto got done_k=%0d done=%0d unstable=%0d extra=%0d required %0d/1/0/0", n, cap_done_k, cap_done_cnt, cap_unstable, cap_extra, L + 3 + s0 + s1);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_compl_i = 1'b0;
        drive_fields(rand_req());
        rd_data_i = '0;
        trn_if.trn_tdst_rdy_n_i = 1'b1;
        trn_if.trn_tdst_dsc_n_i = 1'b1;
        test_reset();
        test_cpld_basic();
        test_cpl_nodata();
        test_be_sweep();
        test_backpressure();
        test_discontinue();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
